// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbitration-mode selector for the multi-master arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_128   = 3'd4,
    HSIZE_256   = 3'd5,
    HSIZE_512   = 3'd6,
    HSIZE_1024  = 3'd7
  } hsize_t;

  typedef enum int {
    ARB_FIXED = 0,
    ARB_RR    = 1
  } arb_mode_e;

  function automatic logic is_active(htrans_t t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Rotating find-first-set: first asserted request at or after i_ptr, wrapping.
module ahb_rr_picker #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_rot_idx;
  logic [IW:0]    w_sum;

  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    w_rot_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_rot_idx = IW'(i);
    end
  end

  // Undo the rotation modulo N (N need not be a power of two).
  assign w_sum   = {1'b0, w_rot_idx} + {1'b0, i_ptr};
  assign o_idx   = (w_sum >= N_W) ? IW'(w_sum - N_W) : w_sum[IW-1:0];
  assign o_valid = |i_req;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign o_grant[gi] = o_valid && (o_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/ahb_multi_arbiter.sv
// AHB arbiter and master-to-slave mux: grant -> address phase -> data phase pipeline,
// every stage advancing only on HREADY, with a bounded tenure per owner.
module ahb_multi_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 8,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ARB_MODE       = 0,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16,
  localparam int IW = $clog2(NUM_MASTERS),
  localparam int HW = $clog2(MAX_HOLD)
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [NUM_MASTERS-1:0]        M_HBUSREQ,
  input  logic [NUM_MASTERS*ADDR_W-1:0] M_HADDR,
  input  logic [NUM_MASTERS*2-1:0]      M_HTRANS,
  input  logic [NUM_MASTERS-1:0]        M_HWRITE,
  input  logic [NUM_MASTERS*3-1:0]      M_HSIZE,
  input  logic [NUM_MASTERS*3-1:0]      M_HBURST,
  input  logic [NUM_MASTERS*DATA_W-1:0] M_HWDATA,
  output logic [NUM_MASTERS-1:0]        M_HGRANT,
  output logic [DATA_W-1:0]             M_HRDATA,
  output logic                          M_HREADY,
  output logic [ADDR_W-1:0]             S_HADDR,
  output logic [1:0]                    S_HTRANS,
  output logic                          S_HWRITE,
  output logic [2:0]                    S_HSIZE,
  output logic [2:0]                    S_HBURST,
  output logic [DATA_W-1:0]             S_HWDATA,
  input  logic [DATA_W-1:0]             S_HRDATA,
  input  logic                          S_HREADY,
  output logic [IW-1:0]                 HMASTER
);

  localparam logic [IW-1:0]          DEF_IDX    = IW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [HW-1:0]          HOLD_LAST  = HW'(MAX_HOLD - 1);
  localparam logic [IW:0]            N_W        = (IW+1)'(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_owner;
  logic [IW-1:0]          r_hmaster;
  logic [IW-1:0]          r_data_owner;
  logic [HW-1:0]          r_hold;
  logic                   r_live;

  logic [ADDR_W-1:0] w_addr  [NUM_MASTERS];
  htrans_t           w_trans [NUM_MASTERS];
  logic [2:0]        w_size  [NUM_MASTERS];
  logic [2:0]        w_burst [NUM_MASTERS];
  logic [DATA_W-1:0] w_wdata [NUM_MASTERS];

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign w_addr[gi]  = M_HADDR[gi*ADDR_W +: ADDR_W];
      assign w_trans[gi] = htrans_t'(M_HTRANS[gi*2 +: 2]);
      assign w_size[gi]  = M_HSIZE[gi*3 +: 3];
      assign w_burst[gi] = M_HBURST[gi*3 +: 3];
      assign w_wdata[gi] = M_HWDATA[gi*DATA_W +: DATA_W];
    end
  endgenerate

  htrans_t w_htrans;

  // The bus shows IDLE until the first clock after reset, whatever the masters drive.
  assign w_htrans = r_live ? w_trans[r_hmaster] : IDLE;
  assign S_HTRANS = w_htrans;
  assign S_HADDR  = w_addr[r_hmaster];
  assign S_HWRITE = M_HWRITE[r_hmaster];
  assign S_HSIZE  = w_size[r_hmaster];
  assign S_HBURST = w_burst[r_hmaster];
  assign S_HWDATA = w_wdata[r_data_owner];
  assign HMASTER  = r_hmaster;
  assign M_HGRANT = r_grant;
  assign M_HRDATA = S_HRDATA;
  assign M_HREADY = S_HREADY;

  logic                   w_expired;
  logic [NUM_MASTERS-1:0] w_others;
  logic [NUM_MASTERS-1:0] w_pick_req;
  logic [IW:0]            w_owner_inc;
  logic [IW-1:0]          w_ptr;
  logic [NUM_MASTERS-1:0] w_pick_grant;
  logic [IW-1:0]          w_pick_idx;
  logic                   w_pick_valid;

  assign w_expired   = (r_hold == HOLD_LAST);
  assign w_others    = M_HBUSREQ & ~r_grant;
  // An expired owner only stays on if nobody else wants the bus.
  assign w_pick_req  = (w_expired && |w_others) ? w_others : M_HBUSREQ;
  assign w_owner_inc = {1'b0, r_owner} + (IW+1)'(1);
  assign w_ptr       = (arb_mode_e'(ARB_MODE) == ARB_RR)
                       ? ((w_owner_inc == N_W) ? '0 : w_owner_inc[IW-1:0])
                       : '0;

  ahb_rr_picker #(.N(NUM_MASTERS)) u_picker (
    .i_req   (w_pick_req),
    .i_ptr   (w_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  logic [NUM_MASTERS-1:0] w_next_grant;
  logic [IW-1:0]          w_next_idx;

  always_comb begin
    w_next_grant = r_grant;
    w_next_idx   = r_owner;
    if (M_HBUSREQ[r_owner] && !w_expired) begin
      w_next_grant = r_grant;
      w_next_idx   = r_owner;
    end else if (w_pick_valid) begin
      w_next_grant = w_pick_grant;
      w_next_idx   = w_pick_idx;
    end else begin
      w_next_grant = DEF_ONEHOT;
      w_next_idx   = DEF_IDX;
    end
  end

  logic w_hold_clear;
  assign w_hold_clear = (w_next_idx != r_owner) || (w_expired && w_pick_valid);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_grant      <= DEF_ONEHOT;
      r_owner      <= DEF_IDX;
      r_hmaster    <= DEF_IDX;
      r_data_owner <= DEF_IDX;
      r_hold       <= '0;
      r_live       <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (S_HREADY) begin
        r_grant      <= w_next_grant;
        r_owner      <= w_next_idx;
        r_hmaster    <= r_owner;
        r_data_owner <= r_hmaster;
        if (w_hold_clear) begin
          r_hold <= '0;
        end else if (is_active(w_htrans) && !w_expired) begin
          r_hold <= r_hold + HW'(1);
        end
      end
    end
  end

endmodule
